// File: rtl/wb_pkg.sv
`default_nettype none
// ==== wb_pkg : shared widths and trace entry type for the writeback stage (rev 1.0) ====
package wb_pkg;
  localparam int ECODE_W    = 8;
  localparam int CSR_ADDR_W = 14;
  localparam int REG_IDX_W  = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [REG_IDX_W-1:0] wnum;
    logic [XLEN-1:0]      wdata;
  } trace_entry_t;
endpackage
`default_nettype wire

// File: rtl/wb_multi_stage_if.sv
`default_nettype none
// ==== wb_multi_stage_if : memory-stage group input, retire ports and debug trace (rev 1.0) ====
interface wb_multi_stage_if
  import wb_pkg::*;
#(
  parameter int LANES = 2
) ();
  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES-1:0]             in_lane_v;
  logic [XLEN*LANES-1:0]        in_pc;
  logic [XLEN*LANES-1:0]        in_result;
  logic [XLEN*LANES-1:0]        in_vaddr;
  logic [LANES-1:0]             in_gr_we;
  logic [REG_IDX_W*LANES-1:0]   in_dest;
  logic [LANES-1:0]             in_ex;
  logic [ECODE_W*LANES-1:0]     in_ecode;
  logic [LANES-1:0]             in_esubcode;
  logic [LANES-1:0]             in_csr_we;
  logic [CSR_ADDR_W*LANES-1:0]  in_csr_addr;
  logic [XLEN*LANES-1:0]        in_csr_wmask;
  logic [XLEN*LANES-1:0]        in_csr_wdata;

  logic [LANES-1:0]             rf_we;
  logic [REG_IDX_W*LANES-1:0]   rf_waddr;
  logic [XLEN*LANES-1:0]        rf_wdata;
  logic                         csr_we;
  logic [CSR_ADDR_W-1:0]        csr_addr;
  logic [XLEN-1:0]              csr_wmask;
  logic [XLEN-1:0]              csr_wdata;
  logic                         exc_valid;
  logic [ECODE_W-1:0]           exc_ecode;
  logic                         exc_esubcode;
  logic [XLEN-1:0]              exc_pc;
  logic [XLEN-1:0]              exc_vaddr;
  logic [XLEN-1:0]              debug_wb_pc;
  logic [3:0]                   debug_wb_rf_we;
  logic [REG_IDX_W-1:0]         debug_wb_rf_wnum;
  logic [XLEN-1:0]              debug_wb_rf_wdata;

  modport master (
    output flush, in_valid, in_lane_v, in_pc, in_result, in_vaddr, in_gr_we, in_dest,
           in_ex, in_ecode, in_esubcode, in_csr_we, in_csr_addr, in_csr_wmask, in_csr_wdata,
    input  in_ready, rf_we, rf_waddr, rf_wdata, csr_we, csr_addr, csr_wmask, csr_wdata,
           exc_valid, exc_ecode, exc_esubcode, exc_pc, exc_vaddr,
           debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  flush, in_valid, in_lane_v, in_pc, in_result, in_vaddr, in_gr_we, in_dest,
           in_ex, in_ecode, in_esubcode, in_csr_we, in_csr_addr, in_csr_wmask, in_csr_wdata,
    output in_ready, rf_we, rf_waddr, rf_wdata, csr_we, csr_addr, csr_wmask, csr_wdata,
           exc_valid, exc_ecode, exc_esubcode, exc_pc, exc_vaddr,
           debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface
`default_nettype wire

// File: rtl/wb_trace_fifo.sv
`default_nettype none
// ==== wb_trace_fifo : multi-push / single-pop trace FIFO with compacting write (rev 1.0) ====
module wb_trace_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LANES = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [LANES-1:0]              push_v,
  input  trace_entry_t [LANES-1:0]      push_data,
  output logic [$clog2(DEPTH):0]        free,
  output logic                          head_valid,
  output trace_entry_t                  head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  trace_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] push_cnt;
  logic [PTR_W-1:0] slot [LANES];
  logic             pop;

  // Each pushing lane lands right after the pushing lanes below it, keeping entries dense.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      slot[i]  = wr_ptr + push_cnt[PTR_W-1:0];
      push_cnt = push_cnt + CNT_W'(push_v[i]);
    end
  end

  assign pop        = (count != '0);
  assign head_valid = pop;
  assign head       = mem[rd_ptr];
  assign free       = CNT_W'(DEPTH) - count + CNT_W'(pop);

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_v[i]) begin
        mem[slot[i]] <= push_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_cnt[PTR_W-1:0];
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + push_cnt - CNT_W'(pop);
    end
  end
endmodule
`default_nettype wire

// File: rtl/wb_multi_stage.sv
`default_nettype none
// ==== wb_multi_stage : multi-lane writeback, GPR/CSR/exception retire and debug trace (rev 1.0) ====
module wb_multi_stage
  import wb_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int TRACE_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rstn,
  wb_multi_stage_if.slave bus
);
  localparam int CNT_W  = $clog2(TRACE_DEPTH) + 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic                        w_valid;
  logic [LANES-1:0]            g_lane_v;
  logic [LANES-1:0]            g_gr_we;
  logic [LANES-1:0]            g_ex;
  logic [LANES-1:0]            g_esubcode;
  logic [LANES-1:0]            g_csr_we;
  logic [XLEN*LANES-1:0]       g_pc;
  logic [XLEN*LANES-1:0]       g_result;
  logic [XLEN*LANES-1:0]       g_vaddr;
  logic [XLEN*LANES-1:0]       g_csr_wmask;
  logic [XLEN*LANES-1:0]       g_csr_wdata;
  logic [REG_IDX_W*LANES-1:0]  g_dest;
  logic [ECODE_W*LANES-1:0]    g_ecode;
  logic [CSR_ADDR_W*LANES-1:0] g_csr_addr;

  logic                        load;
  logic                        fire;
  logic [LANES-1:0]            survive;
  logic [LANES-1:0]            rf_cand;
  logic                        kill_found;
  logic [LANE_W-1:0]           kill_lane;
  logic                        csr_found;
  logic [LANE_W-1:0]           csr_lane;
  logic [CNT_W-1:0]            push_cnt;
  logic [CNT_W-1:0]            fifo_free;
  logic                        head_valid;
  trace_entry_t                head;
  trace_entry_t [LANES-1:0]    push_data;
  logic [XLEN-1:0]             last_pc;
  logic [REG_IDX_W-1:0]        last_wnum;
  logic [XLEN-1:0]             last_wdata;

  assign load         = bus.in_valid && bus.in_ready;
  assign fire         = w_valid && !bus.flush && (fifo_free >= push_cnt);
  assign bus.in_ready = !w_valid || fire;

  // A new group may load in the same cycle the current one retires; flush wins over both.
  always_ff @(posedge clk) begin
    if (!rstn || bus.flush) begin
      w_valid     <= 1'b0;
      g_lane_v    <= '0;
      g_gr_we     <= '0;
      g_ex        <= '0;
      g_esubcode  <= '0;
      g_csr_we    <= '0;
      g_pc        <= '0;
      g_result    <= '0;
      g_vaddr     <= '0;
      g_csr_wmask <= '0;
      g_csr_wdata <= '0;
      g_dest      <= '0;
      g_ecode     <= '0;
      g_csr_addr  <= '0;
    end else if (load) begin
      w_valid     <= 1'b1;
      g_lane_v    <= bus.in_lane_v;
      g_gr_we     <= bus.in_gr_we;
      g_ex        <= bus.in_ex;
      g_esubcode  <= bus.in_esubcode;
      g_csr_we    <= bus.in_csr_we;
      g_pc        <= bus.in_pc;
      g_result    <= bus.in_result;
      g_vaddr     <= bus.in_vaddr;
      g_csr_wmask <= bus.in_csr_wmask;
      g_csr_wdata <= bus.in_csr_wdata;
      g_dest      <= bus.in_dest;
      g_ecode     <= bus.in_ecode;
      g_csr_addr  <= bus.in_csr_addr;
    end else if (fire) begin
      w_valid     <= 1'b0;
    end
  end

  // The oldest excepting lane and everything younger than it do not retire.
  always_comb begin
    kill_found = 1'b0;
    kill_lane  = '0;
    survive    = '0;
    for (int i = 0; i < LANES; i++) begin
      survive[i] = g_lane_v[i] && !g_ex[i] && !kill_found;
      if (g_lane_v[i] && g_ex[i] && !kill_found) begin
        kill_found = 1'b1;
        kill_lane  = LANE_W'(i);
      end
    end
  end

  always_comb begin
    rf_cand  = survive & g_gr_we;
    push_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      push_cnt = push_cnt + CNT_W'(rf_cand[i]);
    end
  end

  always_comb begin
    csr_found = 1'b0;
    csr_lane  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!csr_found && survive[i] && g_csr_we[i]) begin
        csr_found = 1'b1;
        csr_lane  = LANE_W'(i);
      end
    end
  end

  assign bus.rf_we        = fire ? rf_cand : '0;
  assign bus.rf_waddr     = g_dest;
  assign bus.rf_wdata     = g_result;
  assign bus.csr_we       = fire && csr_found;
  assign bus.csr_addr     = g_csr_addr[csr_lane*CSR_ADDR_W +: CSR_ADDR_W];
  assign bus.csr_wmask    = g_csr_wmask[csr_lane*XLEN +: XLEN];
  assign bus.csr_wdata    = g_csr_wdata[csr_lane*XLEN +: XLEN];
  assign bus.exc_valid    = fire && kill_found;
  assign bus.exc_ecode    = g_ecode[kill_lane*ECODE_W +: ECODE_W];
  assign bus.exc_esubcode = g_esubcode[kill_lane];
  assign bus.exc_pc       = g_pc[kill_lane*XLEN +: XLEN];
  assign bus.exc_vaddr    = g_vaddr[kill_lane*XLEN +: XLEN];

  for (genvar i = 0; i < LANES; i++) begin : g_push_lane
    assign push_data[i] = '{pc:    g_pc[i*XLEN +: XLEN],
                            wnum:  g_dest[i*REG_IDX_W +: REG_IDX_W],
                            wdata: g_result[i*XLEN +: XLEN]};
  end

  wb_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .LANES (LANES)
  ) u_trace_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push_v     (bus.rf_we),
    .push_data  (push_data),
    .free       (fifo_free),
    .head_valid (head_valid),
    .head       (head)
  );

  // The head is shown in the cycle it pops; the last popped entry is held while empty.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_pc    <= '0;
      last_wnum  <= '0;
      last_wdata <= '0;
    end else if (head_valid) begin
      last_pc    <= head.pc;
      last_wnum  <= head.wnum;
      last_wdata <= head.wdata;
    end
  end

  assign bus.debug_wb_rf_we    = head_valid ? 4'hf : 4'h0;
  assign bus.debug_wb_pc       = head_valid ? head.pc    : last_pc;
  assign bus.debug_wb_rf_wnum  = head_valid ? head.wnum  : last_wnum;
  assign bus.debug_wb_rf_wdata = head_valid ? head.wdata : last_wdata;
endmodule
`default_nettype wire

// File: doc/wb_multi_stage.md
# wb_multi_stage

Parametrised writeback stage for the multi-issue pipeline: latches up to LANES in-order instructions per cycle from the memory stage, retires them together, and drives LANES register-file write ports plus one CSR write and one exception report per group. It also serialises all retiring register writes into a trace FIFO that drains one entry per cycle onto the single-lane debug_wb_* interface. Its backpressure (in_ready) stalls the memory stage only when the trace FIFO cannot absorb a group.

## Interface
- LANES, 2: instructions per group; lane 0 is oldest.
- TRACE_DEPTH, 8: trace FIFO entries; power of 2, at least 2*LANES.
- Reset is rstn, synchronous, active-low. Clock is clk.
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- flush  in  1  exception/ertn flush from CSR unit; kills the latched group
- in_valid  in  1  group valid from memory stage
- in_ready  out  1  stage can accept a group this cycle
- in_lane_v  in  LANES  per-lane instruction present
- in_pc, in_result, in_vaddr  in  32*LANES each  per-lane pc, writeback value, bad vaddr
- in_gr_we  in  LANES;  in_dest  in  5*LANES  GPR write enable/index
- in_ex  in  LANES;  in_ecode  in  8*LANES;  in_esubcode  in  LANES  exception info
- in_csr_we  in  LANES;  in_csr_addr  in  14*LANES;  in_csr_wmask, in_csr_wdata  in  32*LANES
- rf_we  out  LANES;  rf_waddr  out  5*LANES;  rf_wdata  out  32*LANES  GPR write ports
- csr_we  out  1;  csr_addr  out  14;  csr_wmask, csr_wdata  out  32
- exc_valid  out  1;  exc_ecode  out  8;  exc_esubcode  out  1;  exc_pc, exc_vaddr  out  32
- debug_wb_pc  out  32;  debug_wb_rf_we  out  4;  debug_wb_rf_wnum  out  5;  debug_wb_rf_wdata  out  32

## Operation
- Group register: w_valid plus all in_* fields. Load when in_valid && in_ready. in_ready = !w_valid || fire.
- fire = w_valid && !flush && (fifo_free >= push_cnt). fifo_free counts slots left after this cycle's pop.
- Kill mask: k = lowest lane with in_lane_v && in_ex.
  - Lanes above k are killed.
  - Lane k writes no GPR and no CSR.
  - Lanes below k retire normally.
- rf_we[i] = fire && lane_v[i] && gr_we[i] && not killed && !ex[i].
- rf_waddr and rf_wdata always show the latched fields.
- CSR write: lowest surviving lane with csr_we. csr_we = fire && that lane exists. Any later csr_we lanes are dropped; the decoder issues at most one CSR op per group.
- exc_valid = fire && k exists. exc_* fields come from lane k.
- Trace push: each lane with rf_we[i] set pushes {pc, dest, result}, lane order ascending.
  - push_cnt = popcount(rf_we).
  - Same-cycle pop and push are allowed.
- Trace pop: one entry per cycle whenever the FIFO is non-empty.
  - debug_wb_rf_we = 4'hf and the head fields drive debug_wb_pc, debug_wb_rf_wnum and debug_wb_rf_wdata.
  - When empty: debug_wb_rf_we = 0 and the other debug outputs hold their last value.
- flush:
  - Clears w_valid and the group register next cycle.
  - No rf, CSR or exception output while flush is high.
  - A concurrent in_valid is dropped.
  - The trace FIFO is not cleared; its entries are already committed.
- Reset: w_valid, group fields, FIFO pointers/count and all debug outputs = 0. All other outputs = 0 as a consequence.

## Timing
- 1-cycle latency: a group accepted at edge N drives rf/CSR/exception outputs during cycle N+1, provided fire.
- rf_we, csr_we and exc_valid are combinational from the group register plus flush and fifo_free. They are valid in the cycle of fire only.
- Trace latency: an entry pushed at cycle N's edge appears on debug_wb_* at N+1 at the earliest.
- Stall: if fifo_free < push_cnt, the group holds, in_ready = 0, and no outputs assert. It retires as soon as enough entries drain.
- Full FIFO with an all-exception group (push_cnt = 0): the group still fires.
- Counter width is clog2(TRACE_DEPTH)+1. Pointers wrap modulo TRACE_DEPTH.

## Structure
- Shared package wb_pkg holds:
  - widths: ECODE_W=8, CSR_ADDR_W=14, REG_IDX_W=5, XLEN=32;
  - the trace_entry_t typedef {pc, wnum, wdata}.
- One sub-module, wb_trace_fifo:
  - parameters DEPTH and LANES;
  - multi-push (LANES write ports with a compaction mux), single pop;
  - outputs free count and head.
- Top-level logic: group register, kill-mask priority encoder, CSR lane select, fire logic.

## Test plan
- Two clean lanes: pc 0x1c000000/0x1c000004, dest 3/5, data 0xA/0xB.
  - rf_we = 2'b11 one cycle after accept.
  - debug shows dest 3 and then dest 5 on consecutive cycles.
- Lane 0 ex, ecode 0x0B (SYS):
  - exc_valid = 1 with exc_pc = lane 0 pc;
  - rf_we = 0, csr_we = 0, no trace push.
- Lane 1 ex, lane 0 csr_we to addr 0x0001:
  - csr_we = 1 from lane 0 and rf_we = 2'b01;
  - exc_pc = lane 1 pc.
- Back-to-back full groups with TRACE_DEPTH=4:
  - in_ready drops once fifo_free < 2;
  - no trace entry is lost or reordered over 20 groups.
- flush asserted while a group is latched and in_valid = 1:
  - no rf, CSR or exc output;
  - w_valid = 0 next cycle;
  - earlier trace entries still drain.
- rstn low mid-drain with the FIFO half full:
  - next cycle debug_wb_rf_we = 0, in_ready = 1;
  - all outputs are 0.
